line_clear_scanner: RTL and testbench
=====================================

Name: line_clear_scanner

Overview:
- Upstream neighbour of the BCD score counter.
- After a piece locks, it makes one bottom-to-top pass over the playfield row memory and removes every full row.
- Surviving rows are compacted downward and the vacated top rows are zero-filled.
- For each removed row it emits a one-cycle score_inc pulse, which drives the score counter's enable input.

Parameters:
- ROWS, 20, number of playfield rows; row 0 is the top, ROWS-1 the bottom.
- COLS, 10, cells per row; one bit per cell, 1 = occupied.
- ROW_AW, 5, row address width; must satisfy 2^ROW_AW >= ROWS.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to scan; only sampled in IDLE.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the scan and fill are complete.
- row_addr  output  ROW_AW  row address to the board memory (read and write share it).
- row_rd_data  input  COLS  memory read data; valid the cycle after row_addr is presented (synchronous read, 1-cycle latency).
- row_wr_en  output  1  memory write strobe.
- row_wr_data  output  COLS  memory write data.
- score_inc  output  1  one-cycle pulse per cleared row.
- lines_cleared  output  ROW_AW  number of rows cleared in the last scan.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - busy, done, row_wr_en, score_inc = 0; row_addr, row_wr_data, lines_cleared = 0.
  - rd_ptr and wr_ptr = ROWS-1; internal count = 0.
  - Reset mid-scan abandons the pass; a partially compacted board is acceptable and the game controller re-initialises it.
- States: IDLE, READ, CHECK, WRITE, FILL, DONE.
- IDLE:
  - start=1 loads rd_ptr=wr_ptr=ROWS-1 and count=0, then goes to READ.
  - start=0 stays in IDLE.
- READ:
  - row_addr=rd_ptr; next state is CHECK.
- CHECK (row_rd_data is valid):
  - Full row (all COLS bits set): score_inc=1 this cycle, count+1, no write.
  - Non-full row with wr_ptr==rd_ptr: no write; wr_ptr-1, saturating at 0.
  - Non-full row with wr_ptr!=rd_ptr: latch row_rd_data into the hold register; go to WRITE.
  - Where CHECK does not go to WRITE: if rd_ptr==0, go to FILL when count>0, else DONE; otherwise rd_ptr-1 and go to READ.
- WRITE:
  - row_addr=wr_ptr, row_wr_en=1, row_wr_data=hold register.
  - wr_ptr-1.
  - If rd_ptr==0, go to FILL; otherwise rd_ptr-1 and go to READ.
- FILL:
  - row_addr=wr_ptr, row_wr_en=1, row_wr_data=0.
  - If wr_ptr==0, go to DONE; otherwise wr_ptr-1.
  - On entry, wr_ptr = count-1, so exactly count rows are zeroed (rows count-1 down to 0).
- DONE:
  - done=1 for one cycle; lines_cleared<=count; return to IDLE.
- busy is high in READ, CHECK, WRITE and FILL; it is low in IDLE and DONE.
- lines_cleared holds its value until the next DONE.
- row_wr_en is never high in IDLE, READ, CHECK or DONE.
- Outside WRITE and FILL, row_wr_data is 0.
- Each row is read exactly once; a row is never read after it has been overwritten.
- start while busy or in DONE is ignored; there is no queuing.
- score_inc pulses are never adjacent; there is at least one non-CHECK cycle between them. A single-cycle enable consumer therefore sees every pulse.
- Latency with no clears: 2*ROWS cycles of READ/CHECK, then DONE. done is high on the 41st cycle after the start-sampling edge (ROWS=20).
- Each compaction write adds 1 cycle, and each zero-filled row adds 1 cycle.

Test Plan:
- No full rows (bottom rows 0x155, 0x2AA, rest 0), start -> no row_wr_en, no score_inc, done at cycle 41, lines_cleared=0, memory unchanged.
- Row 19=0x3FF, row 18=0x001, rows 0-17 0 -> one score_inc, then:
  - row 19=0x001, row 18=0, row 0 written 0.
  - lines_cleared=1.
- Rows 19 and 17=0x3FF, row 18=0x0F0, row 16=0x00F -> two score_inc pulses, then:
  - row 19=0x0F0, row 18=0x00F.
  - rows 0-1 zeroed.
  - lines_cleared=2.
- Rows 16-19=0x3FF, row 15=0x101 -> four non-adjacent score_inc pulses, then:
  - row 19=0x101.
  - rows 0-3 zeroed.
  - lines_cleared=4; the downstream score counter advances by 4.
- Row 0=0x3FF only -> one pulse, a single FILL write of 0 to row 0, lines_cleared=1.
- start pulsed during CHECK -> ignored and exactly one done. Then reset asserted mid-WRITE:
  - busy, row_wr_en and score_inc drop to 0 immediately, without waiting for a clock edge.
  - The block is back in IDLE and accepts the next start.

Source files
------------

// File: rtl/line_clear_scanner.sv
// line_clear_scanner: after a piece locks, walks the playfield bottom-to-top
// once, drops every full row, compacts survivors downward and zero-fills the
// vacated top rows. Emits one score_inc pulse per removed row.
module line_clear_scanner #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ROW_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROW_AW-1:0] row_addr,
  input  logic [COLS-1:0]   row_rd_data,
  output logic              row_wr_en,
  output logic [COLS-1:0]   row_wr_data,
  output logic              score_inc,
  output logic [ROW_AW-1:0] lines_cleared
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FILL  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  logic [2:0]        state;
  logic [ROW_AW-1:0] rd_ptr;   // next row to inspect
  logic [ROW_AW-1:0] wr_ptr;   // next destination for a surviving row
  logic [ROW_AW-1:0] count;    // rows removed so far in this pass
  logic [COLS-1:0]   hold;     // surviving row waiting to be written down

  logic row_full;
  assign row_full = &row_rd_data;

  // Scan sequencer: pointers, removed-row count and state transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      rd_ptr        <= LAST_ROW;
      wr_ptr        <= LAST_ROW;
      count         <= '0;
      hold          <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_ptr <= LAST_ROW;
            wr_ptr <= LAST_ROW;
            count  <= '0;
            state  <= S_READ;
          end
        end
        S_READ: state <= S_CHECK;
        S_CHECK: begin
          if (row_full) begin
            count <= count + 1'b1;
          end else if (wr_ptr == rd_ptr && wr_ptr != '0) begin
            // Nothing removed below yet: the row already sits where it belongs.
            wr_ptr <= wr_ptr - 1'b1;
          end
          if (!row_full && wr_ptr != rd_ptr) begin
            hold  <= row_rd_data;
            state <= S_WRITE;
          end else if (rd_ptr == '0) begin
            // A full top row counts too, so look at the incremented count.
            state <= (row_full || count != '0) ? S_FILL : S_DONE;
          end else begin
            rd_ptr <= rd_ptr - 1'b1;
            state  <= S_READ;
          end
        end
        S_WRITE: begin
          // wr_ptr is strictly above rd_ptr here, so it never wraps.
          wr_ptr <= wr_ptr - 1'b1;
          if (rd_ptr == '0) begin
            state <= S_FILL;
          end else begin
            rd_ptr <= rd_ptr - 1'b1;
            state  <= S_READ;
          end
        end
        S_FILL: begin
          // Entered with wr_ptr == count-1: zero rows count-1 .. 0.
          if (wr_ptr == '0) state <= S_DONE;
          else              wr_ptr <= wr_ptr - 1'b1;
        end
        S_DONE: begin
          lines_cleared <= count;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory port and status outputs decoded from the current state.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    row_addr    = '0;
    row_wr_en   = 1'b0;
    row_wr_data = '0;
    score_inc   = 1'b0;
    case (state)
      S_READ: begin
        busy     = 1'b1;
        row_addr = rd_ptr;
      end
      S_CHECK: begin
        busy      = 1'b1;
        score_inc = row_full;
      end
      S_WRITE: begin
        busy        = 1'b1;
        row_addr    = wr_ptr;
        row_wr_en   = 1'b1;
        row_wr_data = hold;
      end
      S_FILL: begin
        busy      = 1'b1;
        row_addr  = wr_ptr;
        row_wr_en = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_clear_scanner.sv
// Bench for line_clear_scanner: a board memory model, a scoreboard fed by the
// stimulus with reference results, and a monitor that checks each scan on done.
module tb_line_clear_scanner;
  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int ROW_AW = 5;
  localparam logic [COLS-1:0] FULL = {COLS{1'b1}};

  typedef logic [ROWS-1:0][COLS-1:0] board_t;
  typedef struct {
    board_t fin;
    int     lc;
    int     lat;
    int     writes;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, row_wr_en, score_inc;
  logic [ROW_AW-1:0] row_addr, lines_cleared;
  logic [COLS-1:0]   row_rd_data, row_wr_data;

  board_t mem;
  board_t init_board = '0;
  logic   load = 1'b0;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  line_clear_scanner #(.ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .row_addr(row_addr), .row_rd_data(row_rd_data), .row_wr_en(row_wr_en),
    .row_wr_data(row_wr_data), .score_inc(score_inc), .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  // Board memory: synchronous read, one-cycle latency, shared address.
  always @(posedge clk) begin
    if (load) mem <= init_board;
    else if (row_wr_en) mem[row_addr] <= row_wr_data;
    row_rd_data <= mem[row_addr];
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: full rows vanish, survivors keep order and stack at the bottom.
  function automatic exp_t model(board_t b);
    exp_t e;
    logic [COLS-1:0] surv[$];
    int cnt = 0;
    int nw = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (b[r] == FULL) cnt++;
      else begin
        if (cnt > 0) nw++;   // something below was removed, so it must move
        surv.push_back(b[r]);
      end
    end
    e.fin = '0;
    foreach (surv[i]) e.fin[ROWS-1-i] = surv[i];
    e.lc     = cnt;
    e.writes = nw + cnt;
    e.lat    = 2 * ROWS + nw + cnt + 1;
    return e;
  endfunction

  task automatic monitor();
    int   cyc = 0, st = 0, pulses = 0, writes = 0, viol = 0, lc_exp = 0;
    bit   prev_inc = 0, pend = 0;
    exp_t e;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (reset) begin
        exp_q.delete();
        pend = 0;
        prev_inc = 0;
        continue;
      end
      if (pend) begin
        check("lines_cleared", int'(lines_cleared), lc_exp);
        pend = 0;
      end
      if (start && !busy && !done) begin
        st = cyc; pulses = 0; writes = 0; viol = 0;
      end
      if (row_wr_en && !busy) viol++;
      if (score_inc && prev_inc) viol++;
      if (!row_wr_en && row_wr_data != '0) viol++;
      prev_inc = score_inc;
      pulses += int'(score_inc);
      writes += int'(row_wr_en);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc - st, e.lat);
          check("score_pulses", pulses, e.lc);
          check("write_count", writes, e.writes);
          check("protocol_violations", viol, 0);
          for (int r = 0; r < ROWS; r++)
            check($sformatf("row%0d", r), int'(mem[r]), int'(e.fin[r]));
          lc_exp = e.lc;
          pend = 1;
        end
      end
    end
  endtask

  task automatic run_scan(board_t b, bit extra);
    @(negedge clk); init_board = b; load = 1'b1;
    @(negedge clk); load = 1'b0;
    exp_q.push_back(model(b));
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (extra) begin
      @(negedge clk); start = 1'b1;   // lands while the first row is in CHECK
      @(negedge clk); start = 1'b0;
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d pending scans expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);        // covers an unwanted second done
  endtask

  initial begin
    board_t b;
    bit     hit;
    fork monitor(); join_none

    // Reset state.
    @(negedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wr_en", int'(row_wr_en), 0);
    check("rst_score_inc", int'(score_inc), 0);
    check("rst_row_addr", int'(row_addr), 0);
    check("rst_wr_data", int'(row_wr_data), 0);
    check("rst_lines_cleared", int'(lines_cleared), 0);
    @(negedge clk); reset = 1'b0;

    b = '0; b[19] = 10'h155; b[18] = 10'h2AA;
    run_scan(b, 0);
    b = '0; b[19] = FULL; b[18] = 10'h001;
    run_scan(b, 0);
    b = '0; b[19] = FULL; b[17] = FULL; b[18] = 10'h0F0; b[16] = 10'h00F;
    run_scan(b, 0);
    b = '0; b[19] = FULL; b[18] = FULL; b[17] = FULL; b[16] = FULL; b[15] = 10'h101;
    run_scan(b, 0);
    b = '0; b[0] = FULL;
    run_scan(b, 0);
    for (int r = 0; r < ROWS; r++) b[r] = FULL;
    run_scan(b, 0);

    // Start while busy must not queue a second scan.
    for (int r = 0; r < ROWS; r++) b[r] = COLS'($urandom);
    b[19] = FULL;
    run_scan(b, 1);

    // Reset in the middle of a compaction write.
    b = '0; b[19] = FULL; b[18] = 10'h0AA;
    @(negedge clk); init_board = b; load = 1'b1;
    @(negedge clk); load = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk); #2;
      hit = row_wr_en;
    end
    check("reached_write", int'(hit), 1);
    reset = 1'b1; #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_wr_en", int'(row_wr_en), 0);
    check("midrst_score_inc", int'(score_inc), 0);
    check("midrst_lines_cleared", int'(lines_cleared), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    b = '0; b[19] = FULL; b[10] = FULL; b[12] = 10'h3F0;
    run_scan(b, 0);

    // Randomized boards.
    for (int n = 0; n < 25; n++) begin
      for (int r = 0; r < ROWS; r++)
        b[r] = ($urandom_range(0, 3) == 0) ? FULL : COLS'($urandom);
      run_scan(b, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
